// File: rtl/seg_scan_driver.sv
// Status-word to 4-digit multiplexed 7-segment driver. A double-dabble converter refreshes the
// display buffer every 10 cycles; a scanner enables one digit per SCAN_DIV cycles. Option: LEAD_ZERO_BLANK_EN.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV   = 125000,
    parameter logic [15:0] DASH_CODE  = 16'hAAAA,
    parameter logic [15:0] BLANK_CODE = 16'hBBBB
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] data_in,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned    CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [3:0] G_DASH  = 4'hA;
    localparam logic [3:0] G_BLANK = 4'hB;

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } conv_state_t;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift {bcd, bin} left.
    function automatic logic [19:0] dabble_step(input logic [11:0] bcd, input logic [7:0] bin);
        logic [11:0] adj;
        // NOTE: blocking assignments are right here; adj is a local temporary, not state.
        adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (adj[4*n +: 4] >= 4'd5)
                adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
        end
        return {adj[10:0], bin, 1'b0};
    endfunction

    // Tens/units glyph pair for one byte; a non-zero hundreds nibble means the value is >= 100.
    function automatic logic [7:0] half_glyphs(input logic [11:0] bcd);
        logic [7:0] pair;
        pair = bcd[7:0];
        if (bcd[11:8] != 4'd0)
            pair = {G_DASH, G_DASH};
        else if (LZB && bcd[7:4] == 4'd0)
            pair = {G_BLANK, bcd[3:0]};
        return pair;
    endfunction

    function automatic logic [7:0] glyph_to_seg(input logic [3:0] g);
        logic [7:0] s;
        case (g)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            G_DASH:  s = 8'hFD;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    conv_state_t       r_state;
    logic [2:0]        r_bit;
    logic [7:0]        r_bin_hi;
    logic [7:0]        r_bin_lo;
    logic [11:0]       r_bcd_hi;
    logic [11:0]       r_bcd_lo;
    logic              r_dash;
    logic              r_blank;
    logic [3:0][3:0]   r_buf;

    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_ptr;
    logic [1:0]        r_sel;
    logic              r_upd;

    logic [19:0]       w_step_hi;
    logic [19:0]       w_step_lo;
    logic [7:0]        w_glyph_hi;
    logic [7:0]        w_glyph_lo;
    logic [1:0]        w_show;

    assign w_step_hi  = dabble_step(r_bcd_hi, r_bin_hi);
    assign w_step_lo  = dabble_step(r_bcd_lo, r_bin_lo);
    assign w_glyph_hi = half_glyphs(r_bcd_hi);
    assign w_glyph_lo = half_glyphs(r_bcd_lo);

    // r_ptr has already stepped past the digit being enabled by the time r_upd fires.
    assign w_show = r_ptr + 2'd1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_bit    <= 3'd0;
            r_bin_hi <= 8'd0;
            r_bin_lo <= 8'd0;
            r_bcd_hi <= 12'd0;
            r_bcd_lo <= 12'd0;
            r_dash   <= 1'b0;
            r_blank  <= 1'b0;
            // NOTE: the buffer is reset on purpose so no stale digit survives an aborted conversion.
            r_buf    <= {4{G_BLANK}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bin_hi <= data_in[15:8];
                    r_bin_lo <= data_in[7:0];
                    r_bcd_hi <= 12'd0;
                    r_bcd_lo <= 12'd0;
                    r_dash   <= (data_in == DASH_CODE);
                    r_blank  <= (data_in == BLANK_CODE);
                    r_bit    <= 3'd0;
                    r_state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    {r_bcd_hi, r_bin_hi} <= w_step_hi;
                    {r_bcd_lo, r_bin_lo} <= w_step_lo;
                    r_bit <= r_bit + 3'd1;
                    if (r_bit == 3'd7)
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (r_dash)
                        r_buf <= {4{G_DASH}};
                    else if (r_blank)
                        r_buf <= {4{G_BLANK}};
                    else
                        r_buf <= {w_glyph_hi, w_glyph_lo};
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Scanner: an and seg come from one register stage, so a digit switch is a single clean edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
            r_ptr <= 2'd3;
            r_sel <= 2'd3;
            r_upd <= 1'b0;
            an    <= 4'b1111;
            seg   <= 8'hFF;
        end else begin
            r_upd <= (r_cnt == CNT_MAX);
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_ptr <= r_ptr - 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_upd) begin
                an    <= ~(4'b0001 << w_show);
                seg   <= glyph_to_seg(r_buf[w_show]);
                r_sel <= w_show;
            end else if (an != 4'b1111) begin
                seg <= glyph_to_seg(r_buf[r_sel]);
            end
        end
    end

endmodule
